// File: rtl/fp_id_table.sv
// Fingerprint ID table: assembles multi-byte IDs from the UART byte stream, searches the
// table one entry per cycle, and enrolls unknown IDs into the next free slot when enabled.
module fp_id_table #(
    parameter int ID_BYTES = 1,
    parameter int DEPTH    = 8,
    parameter int IDX_W    = 3
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Rx_DV,
    input  logic [7:0]       i_Rx_Byte,
    input  logic             i_Enroll_En,
    input  logic             i_Clear,
    output logic             o_Busy,
    output logic             o_Result_Valid,
    output logic             o_Match,
    output logic             o_Stored,
    output logic [IDX_W-1:0] o_Index,
    output logic [IDX_W:0]   o_Count,
    output logic             o_Full,
    output logic             o_Overrun
);

    localparam int ID_W = 8 * ID_BYTES;
    localparam int BC_W = $clog2(ID_BYTES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WRITE, S_REPORT} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   id_next;
    logic [BC_W-1:0]   byte_cnt_q;
    logic              enroll_q;
    logic [IDX_W-1:0]  search_idx_q;
    logic [DEPTH-1:0]  valid_q;
    logic [ID_W-1:0]   table_q [DEPTH];
    logic [IDX_W:0]    count_q;
    logic              match_q, stored_q, overrun_q;
    logic [IDX_W-1:0]  index_q;
    logic [IDX_W-1:0]  free_idx;
    logic              byte_acc, last_byte, entry_hit, last_entry, full_w;

    // First byte received ends up in the MSB position.
    if (ID_BYTES == 1) begin : g_one_byte
        assign id_next = i_Rx_Byte;
    end else begin : g_multi_byte
        assign id_next = {id_q[ID_W-9:0], i_Rx_Byte};
    end

    assign free_idx = count_q[IDX_W-1:0];
    assign full_w   = (count_q == (IDX_W+1)'(DEPTH));

    always_comb begin
        state_d        = state_q;
        byte_acc       = (state_q == S_IDLE) && i_Rx_DV;
        last_byte      = byte_acc && (byte_cnt_q == BC_W'(ID_BYTES - 1));
        entry_hit      = valid_q[search_idx_q] && (table_q[search_idx_q] == id_q);
        last_entry     = (search_idx_q == IDX_W'(DEPTH - 1));
        o_Busy         = (state_q != S_IDLE);
        o_Result_Valid = (state_q == S_REPORT);
        case (state_q)
            S_IDLE:   if (last_byte) state_d = S_SEARCH;
            S_SEARCH: begin
                if (entry_hit)
                    state_d = S_REPORT;
                else if (last_entry)
                    state_d = (enroll_q && !full_w) ? S_WRITE : S_REPORT;
            end
            S_WRITE:  state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // A wipe abandons any in-flight search without reporting it.
        if (i_Clear) state_d = S_IDLE;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Clear) begin
            byte_cnt_q   <= '0;
            search_idx_q <= '0;
            valid_q      <= '0;
            count_q      <= '0;
            match_q      <= 1'b0;
            stored_q     <= 1'b0;
            index_q      <= '0;
        end else begin
            if (byte_acc)
                byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
            if (last_byte)
                search_idx_q <= '0;
            else if (state_q == S_SEARCH)
                search_idx_q <= search_idx_q + 1'b1;

            if (state_q == S_SEARCH && entry_hit) begin
                match_q  <= 1'b1;
                stored_q <= 1'b0;
                index_q  <= search_idx_q;
            end else if (state_q == S_SEARCH && last_entry && state_d == S_REPORT) begin
                match_q  <= 1'b0;
                stored_q <= 1'b0;
                index_q  <= '0;
            end

            // Append-only: the free slot is always the current count.
            if (state_q == S_WRITE) begin
                valid_q[free_idx] <= 1'b1;
                count_q           <= count_q + 1'b1;
                match_q           <= 1'b0;
                stored_q          <= 1'b1;
                index_q           <= free_idx;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) overrun_q <= 1'b0;
        else         overrun_q <= i_Rx_DV && o_Busy;
    end

    // Table payload and latched ID carry no reset; only valid bits qualify entries.
    always_ff @(posedge i_Clock) begin
        if (byte_acc)            id_q              <= id_next;
        if (last_byte)           enroll_q          <= i_Enroll_En;
        if (state_q == S_WRITE)  table_q[free_idx] <= id_q;
    end

    assign o_Match   = match_q;
    assign o_Stored  = stored_q;
    assign o_Index   = index_q;
    assign o_Count   = count_q;
    assign o_Full    = full_w;
    assign o_Overrun = overrun_q;

endmodule

// File: tb/tb_fp_id_table.sv
// Directed bench for fp_id_table (2-byte IDs, 8 entries) with a scoreboard of expected reports.
module tb_fp_id_table;

    logic        clk = 1'b0;
    logic        i_Reset, i_Rx_DV, i_Enroll_En, i_Clear;
    logic [7:0]  i_Rx_Byte;
    logic        o_Busy, o_Result_Valid, o_Match, o_Stored, o_Full, o_Overrun;
    logic [2:0]  o_Index;
    logic [3:0]  o_Count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic       match;
        logic       stored;
        logic [2:0] idx;
        logic [3:0] cnt;
        int         t_exp;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mdl[$];

    fp_id_table #(.ID_BYTES(2), .DEPTH(8), .IDX_W(3)) dut (
        .i_Clock(clk), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
        .i_Enroll_En(i_Enroll_En), .i_Clear(i_Clear), .o_Busy(o_Busy),
        .o_Result_Valid(o_Result_Valid), .o_Match(o_Match), .o_Stored(o_Stored),
        .o_Index(o_Index), .o_Count(o_Count), .o_Full(o_Full), .o_Overrun(o_Overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every result strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (o_Result_Valid === 1'b1) begin
            chk("unexpected_strobe", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("match",   o_Match,  e.match);
                chk("stored",  o_Stored, e.stored);
                chk("index",   o_Index,  e.idx);
                chk("count",   o_Count,  e.cnt);
                chk("latency", cyc,      e.t_exp);
            end
        end
    end

    task automatic send_id(input logic [15:0] id, input logic en, input bit scored);
        exp_t e;
        int   k;
        int   lat;
        k   = -1;
        lat = 0;
        e   = '{1'b0, 1'b0, 3'd0, 4'd0, 0};
        if (scored) begin
            for (int i = 0; i < mdl.size(); i++)
                if (mdl[i] == id && k < 0) k = i;
            if (k >= 0) begin
                e.match = 1'b1; e.idx = 3'(k); lat = 2 + k;
            end else if (en && mdl.size() < 8) begin
                e.stored = 1'b1; e.idx = 3'(mdl.size()); lat = 10;
                mdl.push_back(id);
            end else begin
                lat = 9;
            end
            e.cnt = 4'(mdl.size());
        end
        i_Enroll_En = en;
        for (int b = 0; b < 2; b++) begin
            i_Rx_DV   = 1'b1;
            i_Rx_Byte = (b == 0) ? id[15:8] : id[7:0];
            if (b == 1 && scored) begin
                e.t_exp = cyc + lat;
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        i_Rx_DV = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("result_timeout", exp_q.size() == 0, 1);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        i_Reset = 1'b1; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_Enroll_En = 1'b0; i_Clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    o_Busy, 0);
        chk("rst_rv",      o_Result_Valid, 0);
        chk("rst_match",   o_Match, 0);
        chk("rst_stored",  o_Stored, 0);
        chk("rst_index",   o_Index, 0);
        chk("rst_count",   o_Count, 0);
        chk("rst_full",    o_Full, 0);
        chk("rst_overrun", o_Overrun, 0);
        i_Reset = 1'b0;
        @(negedge clk);

        // Zero ID on an empty table is an ordinary miss.
        send_id(16'h0000, 1'b0, 1'b1);
        wait_done();

        send_id(16'h1234, 1'b1, 1'b1);
        wait_done();
        send_id(16'h1234, 1'b0, 1'b1);
        wait_done();
        chk("match_hold", o_Match, 1);
        send_id(16'h1234, 1'b1, 1'b1);
        wait_done();

        for (int i = 1; i < 8; i++) begin
            send_id(16'hA000 + 16'(i), 1'b1, 1'b1);
            wait_done();
        end
        chk("full_flag",  o_Full, 1);
        chk("full_count", o_Count, 8);
        send_id(16'hBEEF, 1'b1, 1'b1);
        wait_done();
        send_id(16'hA005, 1'b0, 1'b1);
        wait_done();

        // Byte arriving mid-search is dropped and flagged.
        send_id(16'hA002, 1'b0, 1'b1);
        chk("busy_in_search", o_Busy, 1);
        i_Rx_DV = 1'b1; i_Rx_Byte = 8'hAA;
        @(negedge clk);
        i_Rx_DV = 1'b0;
        chk("overrun_pulse", o_Overrun, 1);
        @(negedge clk);
        chk("overrun_clear", o_Overrun, 0);
        wait_done();
        send_id(16'hA003, 1'b0, 1'b1);
        wait_done();

        // Clear during search: no report, table emptied.
        send_id(16'hA007, 1'b0, 1'b0);
        i_Clear = 1'b1;
        @(negedge clk);
        i_Clear = 1'b0;
        mdl.delete();
        chk("clr_busy",  o_Busy, 0);
        chk("clr_count", o_Count, 0);
        chk("clr_full",  o_Full, 0);
        chk("clr_match", o_Match, 0);
        repeat (12) @(negedge clk);
        send_id(16'h1234, 1'b0, 1'b1);
        wait_done();

        // Reset during search behaves the same way.
        send_id(16'h5555, 1'b1, 1'b1);
        wait_done();
        send_id(16'h5555, 1'b0, 1'b0);
        i_Reset = 1'b1;
        @(negedge clk);
        i_Reset = 1'b0;
        mdl.delete();
        chk("rst2_busy",  o_Busy, 0);
        chk("rst2_count", o_Count, 0);
        repeat (12) @(negedge clk);
        send_id(16'h5555, 1'b0, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
